md_ctrl: RTL and testbench

MD_CTRL -- requirements
Module: md_ctrl

---
 rtl/md_ctrl_if.sv | 22 ++
 rtl/md_ctrl.sv | 121 ++++++++++++
 tb/tb_md_ctrl.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/md_ctrl_if.sv
// Multiply/divide control interface: E-stage request, D-stage hazard query, HI/LO readout.
interface md_ctrl_if;
   logic        start;
   logic [2:0]  md_op;
   logic [31:0] A;
   logic [31:0] B;
   logic        md_use_D;
   logic        busy;
   logic        stall_D;
   logic [31:0] HI;
   logic [31:0] LO;

   modport master (
      output start, md_op, A, B, md_use_D,
      input  busy, stall_D, HI, LO
   );

   modport slave (
      input  start, md_op, A, B, md_use_D,
      output busy, stall_D, HI, LO
   );
endinterface

// File: rtl/md_ctrl.sv
// HI/LO multiply/divide controller. The result is computed at the start edge and held in
// res_q; the FSM only models the architectural latency before committing it to HI/LO.
module md_ctrl #(
   parameter int unsigned MUL_CYCLES = 5,
   parameter int unsigned DIV_CYCLES = 10
) (
   input logic    clk,
   input logic    reset,
   md_ctrl_if.slave md
);

   localparam int unsigned MaxCycles = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
   localparam int unsigned CntW      = (MaxCycles > 1) ? $clog2(MaxCycles) : 1;

   typedef enum logic [1:0] {StIdle, StMul, StDiv} state_e;

   state_e            state_q, state_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic [63:0]       res_q, res_d;
   logic              commit_q, commit_d;
   logic [31:0]       hi_q, hi_d;
   logic [31:0]       lo_q, lo_d;

   logic        is_signed;
   logic        is_md_start;
   logic [63:0] a_ext, b_ext, prod;
   logic        a_neg, b_neg;
   logic [31:0] a_mag, b_mag, q_mag, r_mag, quot, rem;

   // Operand conditioning, product and sign-magnitude divide.
   always_comb begin
      is_signed   = (md.md_op == 3'd1) || (md.md_op == 3'd3);
      is_md_start = md.start && (md.md_op >= 3'd1) && (md.md_op <= 3'd4);
      a_ext = {{32{is_signed & md.A[31]}}, md.A};
      b_ext = {{32{is_signed & md.B[31]}}, md.B};
      prod  = a_ext * b_ext;
      a_neg = is_signed & md.A[31];
      b_neg = is_signed & md.B[31];
      a_mag = a_neg ? (32'd0 - md.A) : md.A;
      b_mag = b_neg ? (32'd0 - md.B) : md.B;
      // Magnitudes are unsigned, so 0x80000000 / 1 stays exact and negation restores it.
      q_mag = (b_mag == 32'd0) ? 32'd0 : (a_mag / b_mag);
      r_mag = (b_mag == 32'd0) ? 32'd0 : (a_mag % b_mag);
      quot  = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
      rem   = a_neg ? (32'd0 - r_mag) : r_mag;
   end

   // Next-state: accept ops in idle, count down while busy, commit at the terminal count.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      res_d    = res_q;
      commit_d = commit_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      unique case (state_q)
         StIdle: begin
            if (md.start) begin
               case (md.md_op)
                  3'd1, 3'd2: begin
                     res_d    = prod;
                     commit_d = 1'b1;
                     cnt_d    = CntW'(MUL_CYCLES - 1);
                     state_d  = StMul;
                  end
                  3'd3, 3'd4: begin
                     res_d    = {rem, quot};
                     // Divide by zero burns the cycles but never writes HI/LO.
                     commit_d = (md.B != 32'd0);
                     cnt_d    = CntW'(DIV_CYCLES - 1);
                     state_d  = StDiv;
                  end
                  3'd5:    hi_d = md.A;
                  3'd6:    lo_d = md.A;
                  default: ;
               endcase
            end
         end
         StMul, StDiv: begin
            if (cnt_q == '0) begin
               if (commit_q) begin
                  hi_d = res_q[63:32];
                  lo_d = res_q[31:0];
               end
               state_d = StIdle;
            end else begin
               cnt_d = cnt_q - CntW'(1);
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State registers with asynchronous active-low clear.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= StIdle;
         cnt_q    <= '0;
         res_q    <= '0;
         commit_q <= 1'b0;
         hi_q     <= '0;
         lo_q     <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         res_q    <= res_d;
         commit_q <= commit_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
      end
   end

   // Outputs: busy from state, stall is a pure combinational hazard term.
   always_comb begin
      md.busy    = (state_q != StIdle);
      md.stall_D = md.md_use_D & ((state_q != StIdle) | is_md_start);
      md.HI      = hi_q;
      md.LO      = lo_q;
   end

endmodule

// File: tb/tb_md_ctrl.sv
// Scoreboard bench for md_ctrl: expected HI/LO/latency queued at issue, compared at completion.
module tb_md_ctrl;

   localparam int unsigned MulCycles = 5;
   localparam int unsigned DivCycles = 10;

   logic clk;
   logic reset;

   md_ctrl_if u_if ();

   md_ctrl #(
      .MUL_CYCLES (MulCycles),
      .DIV_CYCLES (DivCycles)
   ) u_dut (
      .clk   (clk),
      .reset (reset),
      .md    (u_if)
   );

   typedef struct {
      string       tag;
      logic [31:0] hi;
      logic [31:0] lo;
      int          cycles;
   } exp_t;

   exp_t        sb_q[$];
   int          n_checks;
   int          n_fail;
   logic [31:0] exp_hi;
   logic [31:0] exp_lo;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
      $fatal(1, "watchdog");
   end

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one op, push its expectation, then track busy and compare on completion.
   task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input bit use_d, input bit poke_busy);
      exp_t   e;
      longint sa, sb, p, q, r;
      int     n;
      e.tag    = tag;
      e.hi     = exp_hi;
      e.lo     = exp_lo;
      e.cycles = 0;
      case (op)
         3'd1: begin
            p = longint'($signed(a)) * longint'($signed(b));
            e.hi = p[63:32];
            e.lo = p[31:0];
            e.cycles = MulCycles;
         end
         3'd2: begin
            p = longint'({32'd0, a}) * longint'({32'd0, b});
            e.hi = p[63:32];
            e.lo = p[31:0];
            e.cycles = MulCycles;
         end
         3'd3, 3'd4: begin
            if (b != 32'd0) begin
               sa = (op == 3'd3) ? longint'($signed(a)) : longint'({32'd0, a});
               sb = (op == 3'd3) ? longint'($signed(b)) : longint'({32'd0, b});
               q = sa / sb;
               r = sa % sb;
               e.lo = q[31:0];
               e.hi = r[31:0];
            end
            e.cycles = DivCycles;
         end
         3'd5:    e.hi = a;
         3'd6:    e.lo = a;
         default: ;
      endcase
      sb_q.push_back(e);

      u_if.start    = 1'b1;
      u_if.md_op    = op;
      u_if.A        = a;
      u_if.B        = b;
      u_if.md_use_D = use_d;
      #1;
      check_eq({tag, "/stall_issue"}, 64'(u_if.stall_D),
               64'(use_d && (op >= 3'd1) && (op <= 3'd4)));
      tick();
      u_if.start = 1'b0;
      u_if.md_op = 3'd0;
      n = 0;
      while (u_if.busy && n < 200) begin
         if (n == 0) begin
            check_eq({tag, "/hi_hold"}, 64'(u_if.HI), 64'(exp_hi));
            check_eq({tag, "/lo_hold"}, 64'(u_if.LO), 64'(exp_lo));
            check_eq({tag, "/stall_busy"}, 64'(u_if.stall_D), 64'(use_d));
         end
         if (poke_busy && n == 1) begin
            u_if.start = 1'b1;
            u_if.md_op = 3'd5;
            u_if.A     = 32'hDEAD_BEEF;
         end else begin
            u_if.start = 1'b0;
            u_if.md_op = 3'd0;
         end
         n++;
         tick();
      end
      u_if.start = 1'b0;
      u_if.md_op = 3'd0;
      e = sb_q.pop_front();
      check_eq({e.tag, "/busy_cycles"}, 64'(n), 64'(e.cycles));
      check_eq({e.tag, "/hi"}, 64'(u_if.HI), 64'(e.hi));
      check_eq({e.tag, "/lo"}, 64'(u_if.LO), 64'(e.lo));
      check_eq({e.tag, "/stall_done"}, 64'(u_if.stall_D), 64'd0);
      exp_hi = e.hi;
      exp_lo = e.lo;
      u_if.md_use_D = 1'b0;
   endtask

   initial begin
      n_checks      = 0;
      n_fail        = 0;
      exp_hi        = '0;
      exp_lo        = '0;
      reset         = 1'b0;
      u_if.start    = 1'b0;
      u_if.md_op    = 3'd0;
      u_if.A        = '0;
      u_if.B        = '0;
      u_if.md_use_D = 1'b1;
      #12;
      check_eq("rst/busy", 64'(u_if.busy), 64'd0);
      check_eq("rst/hi", 64'(u_if.HI), 64'd0);
      check_eq("rst/lo", 64'(u_if.LO), 64'd0);
      check_eq("rst/stall_idle", 64'(u_if.stall_D), 64'd0);
      u_if.start = 1'b1;
      u_if.md_op = 3'd1;
      #1;
      check_eq("rst/stall_comb", 64'(u_if.stall_D), 64'd1);
      u_if.start    = 1'b0;
      u_if.md_op    = 3'd0;
      u_if.md_use_D = 1'b0;
      tick();
      reset = 1'b1;
      tick();

      run_op("mult_neg", 3'd1, 32'hFFFF_FFFE, 32'd3, 1'b0, 1'b0);
      run_op("multu_max", 3'd2, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0);
      run_op("div_neg", 3'd3, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
      run_op("divu", 3'd4, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
      run_op("div_ovf", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
      run_op("mthi", 3'd5, 32'h11, 32'd0, 1'b0, 1'b0);
      run_op("mtlo", 3'd6, 32'h22, 32'd0, 1'b0, 1'b0);
      run_op("div_zero", 3'd3, 32'h1234, 32'd0, 1'b0, 1'b0);
      run_op("divu_zero", 3'd4, 32'h1234, 32'd0, 1'b0, 1'b0);
      run_op("op_none", 3'd0, 32'h55, 32'h66, 1'b1, 1'b0);
      run_op("op_rsvd", 3'd7, 32'h55, 32'h66, 1'b1, 1'b0);
      run_op("mult_stall", 3'd1, 32'h0001_0003, 32'h0002_0005, 1'b1, 1'b1);
      run_op("div_poke", 3'd3, 32'h7FFF_FFFF, 32'hFFFF_FFFD, 1'b1, 1'b1);
      for (int i = 0; i < 8; i++) begin
         logic [2:0]  rop;
         logic [31:0] ra, rb;
         rop = 3'($urandom_range(1, 4));
         ra  = $urandom;
         rb  = (i == 5) ? 32'd0 : $urandom;
         if (i[0]) rb = rb >> $urandom_range(0, 31);
         run_op($sformatf("rand%0d", i), rop, ra, rb, i[1], 1'b0);
      end

      // Abort a divide with reset at the fourth busy cycle.
      run_op("pre_hi", 3'd5, 32'hAAAA_0001, 32'd0, 1'b0, 1'b0);
      u_if.start = 1'b1;
      u_if.md_op = 3'd3;
      u_if.A     = 32'd100;
      u_if.B     = 32'd7;
      tick();
      u_if.start = 1'b0;
      u_if.md_op = 3'd0;
      tick();
      tick();
      tick();
      check_eq("abort/busy_before", 64'(u_if.busy), 64'd1);
      reset         = 1'b0;
      u_if.md_use_D = 1'b1;
      #1;
      check_eq("abort/busy", 64'(u_if.busy), 64'd0);
      check_eq("abort/hi", 64'(u_if.HI), 64'd0);
      check_eq("abort/lo", 64'(u_if.LO), 64'd0);
      check_eq("abort/stall", 64'(u_if.stall_D), 64'd0);
      u_if.md_use_D = 1'b0;
      tick();
      reset  = 1'b1;
      exp_hi = '0;
      exp_lo = '0;
      run_op("post_mtlo", 3'd6, 32'h5, 32'd0, 1'b0, 1'b0);
      tick();
      check_eq("post/busy", 64'(u_if.busy), 64'd0);
      check_eq("post/hi", 64'(u_if.HI), 64'd0);
      check_eq("post/lo", 64'(u_if.LO), 64'd5);
      check_eq("post/sb_empty", 64'(sb_q.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
